// File: rtl/ex_mem_stage.sv
// EX stage datapath and EX/MEM pipeline latch: ALU, branch target adder and
// destination mux feed a one-cycle register with stall/flush control.
module ex_mem_stage #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [1:0]         WB_in,
  input  logic [2:0]         M_in,
  input  logic [4:0]         EX_in,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  input  logic [31:0]        Extended,
  input  logic [31:0]        npc,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  output logic               out_valid,
  output logic [1:0]         WB_out,
  output logic [2:0]         M_out,
  output logic [31:0]        alu_result,
  output logic [31:0]        B_out,
  output logic [31:0]        branch_target,
  output logic               zero,
  output logic               overflow,
  output logic [4:0]         dest_reg,
  output logic [COUNT_W-1:0] ex_count
);

  // Handshake: in_valid qualifies the incoming bundle; there is no ready, the
  // upstream stage observes stall and must hold its bundle while it is high.
  logic        reg_dst;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [31:0] op2;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [31:0] slt_res;
  logic [31:0] res_next;
  logic        ovf_next;
  logic [31:0] bt_next;
  logic [4:0]  dest_next;

  assign reg_dst = EX_in[4];
  assign alu_src = EX_in[3];
  assign alu_op  = EX_in[2:0];
  assign op2     = alu_src ? Extended : B;
  assign sum     = A + op2;
  assign diff    = A - op2;
  assign add_ovf = (A[31] == op2[31]) && (sum[31] != A[31]);
  assign sub_ovf = (A[31] != op2[31]) && (diff[31] != A[31]);
  assign slt_res = {31'b0, ($signed(A) < $signed(op2))};

  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    case (alu_op)
      3'b000: begin res_next = sum;  ovf_next = add_ovf; end
      3'b001: begin res_next = diff; ovf_next = sub_ovf; end
      3'b010: begin
        // R-type: funct field sits in the low bits of the sign-extended immediate
        case (Extended[5:0])
          6'b100000: begin res_next = sum;  ovf_next = add_ovf; end
          6'b100010: begin res_next = diff; ovf_next = sub_ovf; end
          6'b100100: res_next = A & op2;
          6'b100101: res_next = A | op2;
          6'b101010: res_next = slt_res;
          default:   res_next = '0;
        endcase
      end
      3'b011:  res_next = A & op2;
      3'b100:  res_next = A | op2;
      3'b101:  res_next = slt_res;
      default: res_next = '0;
    endcase
  end

  assign bt_next   = npc + {Extended[29:0], 2'b00};
  assign dest_next = reg_dst ? rd : rt;

  // Flush only kills control; data stays put so a flushed slot is inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      WB_out        <= '0;
      M_out         <= '0;
      alu_result    <= '0;
      B_out         <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      dest_reg      <= '0;
      ex_count      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      WB_out    <= '0;
      M_out     <= '0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      WB_out        <= in_valid ? WB_in : 2'b00;
      M_out         <= in_valid ? M_in : 3'b000;
      alu_result    <= res_next;
      B_out         <= B;
      branch_target <= bt_next;
      zero          <= (res_next == 32'd0);
      overflow      <= ovf_next;
      dest_reg      <= dest_next;
      if (in_valid) ex_count <= ex_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: driver pushes hand-computed expectations,
// a negedge monitor pops and compares one entry per latched cycle.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu;
    logic [31:0] bo;
    logic [31:0] bt;
    logic        z;
    logic        ov;
    logic [4:0]  dst;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  WB_in = '0;
  logic [2:0]  M_in = '0;
  logic [4:0]  EX_in = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Extended = '0;
  logic [31:0] npc = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic        out_valid;
  logic [1:0]  WB_out;
  logic [2:0]  M_out;
  logic [31:0] alu_result;
  logic [31:0] B_out;
  logic [31:0] branch_target;
  logic        zero;
  logic        overflow;
  logic [4:0]  dest_reg;
  logic [3:0]  ex_count;

  exp_t exp_q[$];
  bit   due = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_stage #(.COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .WB_in(WB_in), .M_in(M_in), .EX_in(EX_in), .A(A), .B(B), .Extended(Extended),
    .npc(npc), .rt(rt), .rd(rd), .out_valid(out_valid), .WB_out(WB_out),
    .M_out(M_out), .alu_result(alu_result), .B_out(B_out),
    .branch_target(branch_target), .zero(zero), .overflow(overflow),
    .dest_reg(dest_reg), .ex_count(ex_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [1:0] wb, input logic [2:0] m,
                              input logic [31:0] alu, input logic [31:0] bo,
                              input logic [31:0] bt, input logic z, input logic ov,
                              input logic [4:0] dst, input logic [3:0] cnt);
    exp_t e;
    e.v = v; e.wb = wb; e.m = m; e.alu = alu; e.bo = bo; e.bt = bt;
    e.z = z; e.ov = ov; e.dst = dst; e.cnt = cnt;
    return e;
  endfunction

  // driver
  task automatic step(input logic s, input logic f, input logic v, input logic [1:0] wb,
                      input logic [2:0] m, input logic [4:0] ex, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ext, input logic [31:0] pc,
                      input logic [4:0] t, input logic [4:0] d, input exp_t e);
    @(negedge clk);
    stall = s; flush = f; in_valid = v; WB_in = wb; M_in = m; EX_in = ex;
    A = a; B = b; Extended = ext; npc = pc; rt = t; rd = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " WB_out"}, 32'(WB_out), 0);
    chk({tag, " M_out"}, 32'(M_out), 0);
    chk({tag, " alu_result"}, alu_result, 0);
    chk({tag, " B_out"}, B_out, 0);
    chk({tag, " branch_target"}, branch_target, 0);
    chk({tag, " zero"}, 32'(zero), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " dest_reg"}, 32'(dest_reg), 0);
    chk({tag, " ex_count"}, 32'(ex_count), 0);
  endtask

  // scoreboard monitor: an entry is due after each rising edge that followed a push
  always @(posedge clk) due = (exp_q.size() != 0);

  always @(negedge clk) begin
    if (due) begin
      exp_t e;
      e = exp_q.pop_front();
      due = 1'b0;
      chk("out_valid", 32'(out_valid), 32'(e.v));
      chk("WB_out", 32'(WB_out), 32'(e.wb));
      chk("M_out", 32'(M_out), 32'(e.m));
      chk("alu_result", alu_result, e.alu);
      chk("B_out", B_out, e.bo);
      chk("branch_target", branch_target, e.bt);
      chk("zero", 32'(zero), 32'(e.z));
      chk("overflow", 32'(overflow), 32'(e.ov));
      chk("dest_reg", 32'(dest_reg), 32'(e.dst));
      chk("ex_count", 32'(ex_count), 32'(e.cnt));
    end
  end

  initial begin
    exp_t xe;
    exp_t fe;
    int guard;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // add with immediate
    step(0,0,1, 2'b10, 3'b000, 5'b01000, 32'd5, 32'h11, 32'd7, 32'h40, 5'd3, 5'd4,
         mk(1, 2'b10, 3'b000, 32'd12, 32'h11, 32'h5C, 0, 0, 5'd3, 4'd1));
    // R-type sub with signed overflow, rd destination
    step(0,0,1, 2'b10, 3'b000, 5'b10010, 32'h80000000, 32'd1, 32'h22, 32'h100, 5'd2, 5'd9,
         mk(1, 2'b10, 3'b000, 32'h7FFFFFFF, 32'd1, 32'h188, 0, 1, 5'd9, 4'd2));
    // branch compare, negative offset
    step(0,0,1, 2'b00, 3'b100, 5'b00001, 32'd3, 32'd3, 32'hFFFFFFFF, 32'h100, 5'd5, 5'd6,
         mk(1, 2'b00, 3'b100, 32'd0, 32'd3, 32'hFC, 1, 0, 5'd5, 4'd3));
    // and
    step(0,0,1, 2'b11, 3'b010, 5'b00011, 32'hF0F000FF, 32'h0FF00F0F, 32'd0, 32'd0, 5'd1, 5'd2,
         mk(1, 2'b11, 3'b010, 32'h00F0000F, 32'h0FF00F0F, 32'd0, 0, 0, 5'd1, 4'd4));
    // R-type or
    step(0,0,1, 2'b10, 3'b000, 5'b10010, 32'h1200, 32'h34, 32'h25, 32'd4, 5'd8, 5'd7,
         mk(1, 2'b10, 3'b000, 32'h1234, 32'h34, 32'h98, 0, 0, 5'd7, 4'd5));
    // signed slt: -1 < 1
    step(0,0,1, 2'b10, 3'b001, 5'b00101, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd8, 5'd10, 5'd11,
         mk(1, 2'b10, 3'b001, 32'd1, 32'd1, 32'd8, 0, 0, 5'd10, 4'd6));
    // bubble: control cleared, data still latched, count held
    step(0,0,0, 2'b11, 3'b111, 5'b01000, 32'd1, 32'd0, 32'd2, 32'd0, 5'd0, 5'd31,
         mk(0, 2'b00, 3'b000, 32'd3, 32'd0, 32'd8, 0, 0, 5'd0, 4'd6));
    // add signed overflow
    step(0,0,1, 2'b10, 3'b000, 5'b00000, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 5'd12, 5'd1,
         mk(1, 2'b10, 3'b000, 32'h80000000, 32'd1, 32'd0, 0, 1, 5'd12, 4'd7));
    // unused alu_op gives 0
    step(0,0,1, 2'b01, 3'b000, 5'b00110, 32'd5, 32'd6, 32'd0, 32'd0, 5'd14, 5'd15,
         mk(1, 2'b01, 3'b000, 32'd0, 32'd6, 32'd0, 1, 0, 5'd14, 4'd8));
    // unknown R-type funct gives 0
    xe = mk(1, 2'b10, 3'b010, 32'd0, 32'd1, 32'hFC, 1, 0, 5'd13, 4'd9);
    step(0,0,1, 2'b10, 3'b010, 5'b10010, 32'd1, 32'd1, 32'h3F, 32'd0, 5'd3, 5'd13, xe);

    // stall twice with fresh inputs, then stall+flush, then flush alone
    step(1,0,1, 2'b11, 3'b111, 5'b01000, 32'hDEAD, 32'hBEEF, 32'd9, 32'h500, 5'd20, 5'd21, xe);
    step(1,0,1, 2'b01, 3'b001, 5'b00001, 32'h1, 32'h2, 32'd3, 32'h600, 5'd22, 5'd23, xe);
    fe = xe; fe.v = 1'b0; fe.wb = 2'b00; fe.m = 3'b000;
    step(1,1,1, 2'b11, 3'b111, 5'b01000, 32'h5, 32'h6, 32'd7, 32'h700, 5'd24, 5'd25, fe);
    step(0,1,1, 2'b11, 3'b111, 5'b01000, 32'h8, 32'h9, 32'd1, 32'h800, 5'd26, 5'd27, fe);

    // seven more valid instructions bring the total to 16: 4-bit counter wraps to 0
    for (int k = 0; k < 7; k++)
      step(0,0,1, 2'b10, 3'b000, 5'b01000, 32'(k), 32'd0, 32'd1, 32'd0, 5'd4, 5'd5,
           mk(1, 2'b10, 3'b000, 32'(k + 1), 32'd0, 32'd4, 0, 0, 5'd4, 4'(10 + k)));

    // freeze the pipe, then pulse reset between edges
    @(negedge clk);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    in_valid = 1'b1;
    #1 rst_n = 1'b1;

    // first instruction after reset counts from zero
    step(0,0,1, 2'b10, 3'b000, 5'b01000, 32'd2, 32'd0, 32'd3, 32'd0, 5'd6, 5'd7,
         mk(1, 2'b10, 3'b000, 32'd5, 32'd0, 32'd12, 0, 0, 5'd6, 4'd1));
    @(negedge clk);
    stall = 1'b1;

    guard = 0;
    while ((exp_q.size() != 0 || due) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0 || due) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter: COUNT_W, default 32, width of the executed-instruction counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: stall  input  1  hold all registered outputs this cycle.
REQ-005 SHALL have port: flush  input  1  insert bubble into the EX/MEM latch this cycle.
REQ-006 SHALL have port: in_valid  input  1  ID/EX bundle holds a real instruction.
REQ-007 SHALL have ports: WB_in  input  2  {reg_write, mem_to_reg}; M_in  input  3  {branch, mem_read, mem_write}; EX_in  input  5  {reg_dst, alu_src, alu_op[2:0]}.
REQ-008 SHALL have ports: A, B, Extended, npc  input  32 each  register operands, sign-extended immediate, next PC.
REQ-009 SHALL have ports: rt, rd  input  5 each  instruction fields [20:16] and [15:11].
REQ-010 SHALL have ports: out_valid  output  1; WB_out  output  2; M_out  output  3  registered copies of the control groups.
REQ-011 SHALL have ports: alu_result, B_out, branch_target  output  32 each; zero, overflow  output  1 each; dest_reg  output  5.
REQ-012 SHALL have port: ex_count  output  COUNT_W  number of valid instructions latched since reset.

Function
REQ-013 SHALL compute all results combinationally from inputs and register them on the rising clk edge; latency exactly 1 cycle.
REQ-014 SHALL select ALU operand 2 as Extended when alu_src=1, else B.
REQ-015 SHALL decode alu_op: 000 add, 001 sub, 010 R-type via Extended[5:0], 011 and, 100 or, 101 slt (signed), 110/111 result 0.
REQ-016 SHALL decode R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt signed; any other funct gives result 0.
REQ-017 SHALL compute add/sub modulo 2^32; overflow=1 only for signed overflow of an add or sub, else 0.
REQ-018 SHALL set zero=1 iff the 32-bit ALU result is 0.
REQ-019 SHALL compute branch_target = npc + (Extended << 2), modulo 2^32.
REQ-020 SHALL set dest_reg = rd when reg_dst=1, else rt; B_out = B (store data, unmuxed).
REQ-021 SHALL, with stall=0 and flush=0, latch out_valid=in_valid, WB_out=WB_in, M_out=M_in and all data results.
REQ-022 SHALL, when in_valid=0 and no stall/flush, clear WB_out and M_out to 0 (bubble) while still latching data fields.
REQ-023 SHALL, when stall=1 and flush=0, hold every output including ex_count unchanged; inputs are ignored.
REQ-024 SHALL, when flush=1, set out_valid=0, WB_out=0, M_out=0 on that edge, regardless of stall; data outputs are don't-care but SHALL be held.
REQ-025 SHALL increment ex_count by 1 on each edge where a valid instruction is latched (in_valid=1, stall=0, flush=0); wraps from all-ones to 0.

Reset
REQ-026 SHALL, while rst_n=0, force all outputs to 0 immediately, independent of clk.
REQ-027 SHALL, on rst_n deassertion, resume normal operation at the next rising clk edge; an instruction in flight at reset is discarded, not counted.

Verification
REQ-028 SHALL verify add: alu_op=000, alu_src=1, A=5, Extended=7, in_valid=1 -> next edge alu_result=12, zero=0, overflow=0, out_valid=1, ex_count=1.
REQ-029 SHALL verify R-type sub overflow: alu_op=010, funct=100010, alu_src=0, A=0x80000000, B=1 -> alu_result=0x7FFFFFFF, overflow=1; reg_dst=1, rd=9 -> dest_reg=9.
REQ-030 SHALL verify branch: npc=0x00000100, Extended=0xFFFFFFFF, A=B=3, alu_op=001 -> branch_target=0x000000FC, zero=1, M_out=M_in.
REQ-031 SHALL verify stall then flush: latch instr X; stall=1 with new inputs for 2 cycles -> outputs remain X, ex_count unchanged; stall=1 and flush=1 -> out_valid=0, WB_out=0, M_out=0.
REQ-032 SHALL verify async reset: drive rst_n=0 between edges with out_valid=1 -> all outputs 0 before next edge; counter wrap with COUNT_W=4: 16 valid instructions -> ex_count=0.
